// File: rtl/seq_pkg.sv
// Shared constants, state encoding and pointer helper for the step sequencer.
package seq_pkg;

  localparam int STEPS     = 8;
  localparam int VOICES    = 8;
  localparam int SW        = $clog2(STEPS);
  localparam int MIN_TEMPO = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    SOUND = 2'd3
  } state_t;

  // Step after ptr: wraps to 0 once ptr reaches or passes the loop end.
  // The loop end may have been lowered below ptr while the step was playing.
  function automatic logic [SW-1:0] next_ptr(input logic [SW-1:0] ptr,
                                             input logic [SW-1:0] last);
    return (ptr >= last) ? '0 : ptr + SW'(1);
  endfunction

endpackage

// File: rtl/step_timer.sv
// Tempo counter for one sounding step, with gate-off and end-of-step compares.
// tempo_div is clamped up to MIN_TEMPO and gate_len is clamped down to the
// last count of the step; both are sampled live on every cycle.
module step_timer
  import seq_pkg::*;
#(
  parameter int TW = 28
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          run,
  input  logic [TW-1:0] tempo_div,
  input  logic [TW-1:0] gate_len,
  output logic          gate_off,
  output logic          step_end
);

  logic [TW-1:0] count;
  logic [TW-1:0] eff_tempo;
  logic [TW-1:0] last;
  logic [TW-1:0] eff_gate;

  // Clamp the programmed lengths and compare them against the running count.
  // NOTE: every signal written in always_comb gets a value on every path so no latch is inferred.
  always_comb begin
    eff_tempo = (tempo_div < TW'(MIN_TEMPO)) ? TW'(MIN_TEMPO) : tempo_div;
    last      = eff_tempo - TW'(1);
    eff_gate  = (gate_len > last) ? last : gate_len;
    // >= rather than == so a length lowered mid-step still closes at the next compare.
    gate_off  = (count >= eff_gate);
    step_end  = (count >= last);
  end

  // Count clk cycles of the current step; restarted when the row arrives.
  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      count <= count + TW'(1);
    end
  end

endmodule

// File: rtl/step_scheduler.sv
// Playback controller for the step grid: walks the step pointer, fetches each
// row over a req/ack handshake and drives the per-voice gates for gate_len clks.
module step_scheduler
  import seq_pkg::*;
#(
  parameter int TW = 28
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play,
  input  logic              stop,
  input  logic [TW-1:0]     tempo_div,
  input  logic [TW-1:0]     gate_len,
  input  logic [SW-1:0]     loop_len,
  output logic              row_req,
  output logic [SW-1:0]     row_addr,
  input  logic              row_ack,
  input  logic [VOICES-1:0] row_data,
  output logic [VOICES-1:0] gate,
  output logic [SW-1:0]     step,
  output logic              step_stb,
  output logic              playing
);

  state_t            state_q;
  state_t            state_d;
  logic [SW-1:0]     pointer;
  logic [VOICES-1:0] row_q;
  logic              take_ack;
  logic              advance;
  logic              gate_off;
  logic              step_end;

  step_timer #(.TW(TW)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (take_ack | stop),
    .run       (state_q == SOUND),
    .tempo_div (tempo_div),
    .gate_len  (gate_len),
    .gate_off  (gate_off),
    .step_end  (step_end)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; stop overrides everything, including a same-cycle play or ack.
  always_comb begin
    state_d  = state_q;
    take_ack = 1'b0;
    advance  = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  if (play) state_d = FETCH;
        FETCH: state_d = WAIT;
        WAIT: begin
          if (row_ack) begin
            take_ack = 1'b1;
            state_d  = SOUND;
          end
        end
        SOUND: begin
          if (step_end) begin
            advance = 1'b1;
            state_d = FETCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Pointer, latched row and step cursor. The latched row is cleared once the
  // gate closes so a later gate_len increase cannot reopen it within the step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pointer  <= '0;
      row_q    <= '0;
      step     <= '0;
      step_stb <= 1'b0;
    end else begin
      step_stb <= take_ack;
      if (stop) begin
        pointer <= '0;
        row_q   <= '0;
        step    <= '0;
      end else begin
        if (take_ack) begin
          row_q <= row_data;
          step  <= pointer;
        end else if (state_q == SOUND && gate_off) begin
          row_q <= '0;
        end
        if (advance) begin
          pointer <= next_ptr(pointer, loop_len);
        end
      end
    end
  end

  // Outputs decode from registered state so reset clears them without waiting for a clock.
  // The pointer only moves in SOUND, so row_addr is stable for the whole request.
  always_comb begin
    row_req  = (state_q == FETCH) || (state_q == WAIT);
    row_addr = pointer;
    playing  = (state_q != IDLE);
    gate     = (state_q == SOUND && !gate_off) ? row_q : '0;
  end

endmodule

// File: tb/tb_step_scheduler.sv
// Directed bench for step_scheduler with a small pattern-store responder.
module tb_step_scheduler;
  import seq_pkg::*;

  localparam int TW = 28;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              play = 1'b0;
  logic              stop = 1'b0;
  logic [TW-1:0]     tempo_div = '0;
  logic [TW-1:0]     gate_len = '0;
  logic [SW-1:0]     loop_len = '0;
  logic              row_req;
  logic [SW-1:0]     row_addr;
  logic              row_ack = 1'b0;
  logic [VOICES-1:0] row_data = '0;
  logic [VOICES-1:0] gate;
  logic [SW-1:0]     step;
  logic              step_stb;
  logic              playing;

  step_scheduler #(.TW(TW)) dut (
    .clk(clk), .rst(rst), .play(play), .stop(stop),
    .tempo_div(tempo_div), .gate_len(gate_len), .loop_len(loop_len),
    .row_req(row_req), .row_addr(row_addr), .row_ack(row_ack), .row_data(row_data),
    .gate(gate), .step(step), .step_stb(step_stb), .playing(playing)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int cyc    = 0;

  logic [VOICES-1:0] rows [STEPS];
  int ack_delay  = 1;
  bit ack_block  = 1'b0;
  bit store_hold = 1'b0;
  int req_age    = 0;

  int                stb_cyc  [$];
  int                stb_step [$];
  logic [VOICES-1:0] stb_gate [$];
  int                gate_hist[$];
  int                gate_cnt = 0;

  // One clock: sample at the falling edge, log strobes and gate time, then
  // drive the pattern store for the next rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (step_stb) begin
      stb_cyc.push_back(cyc);
      stb_step.push_back(int'(step));
      stb_gate.push_back(gate);
      gate_hist.push_back(gate_cnt);
      gate_cnt = 0;
    end
    if (gate != '0) gate_cnt++;
    if (!store_hold) begin
      if (row_req) begin
        if (!ack_block && req_age >= ack_delay) begin
          row_ack  = 1'b1;
          row_data = rows[row_addr];
        end else begin
          row_ack = 1'b0;
        end
        req_age++;
      end else begin
        row_ack = 1'b0;
        req_age = 0;
      end
    end
  endtask

  task automatic clear_log();
    stb_cyc.delete();
    stb_step.delete();
    stb_gate.delete();
    gate_hist.delete();
    gate_cnt = 0;
  endtask

  task automatic pulse_play();
    play = 1'b1;
    tick();
    play = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
  endtask

  // Tick until n strobes have been logged or the budget runs out.
  task automatic wait_stb(input int n, input int budget);
    int spent = 0;
    while (stb_step.size() < n && spent < budget) begin
      tick();
      spent++;
    end
    total++;
    if (stb_step.size() < n)
      $display("FAIL wait_stb: got %0d strobes, required %0d within %0d cycles", stb_step.size(), n, budget);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    total++; if (gate !== '0)    $display("FAIL reset_gate: got %h, required 00", gate); else passed++;
    total++; if (row_req !== 1'b0) $display("FAIL reset_row_req: got %b, required 0", row_req); else passed++;
    total++; if (playing !== 1'b0) $display("FAIL reset_playing: got %b, required 0", playing); else passed++;
    total++; if (step !== '0 || step_stb !== 1'b0 || row_addr !== '0)
      $display("FAIL reset_step: step=%0d stb=%b addr=%0d, required 0/0/0", step, step_stb, row_addr); else passed++;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic_loop();
    tempo_div = 28'd10;
    gate_len  = 28'd4;
    loop_len  = 3'd7;
    ack_delay = 1;
    clear_log();
    pulse_play();
    wait_stb(10, 200);
    if (stb_step.size() >= 10) begin
      for (int i = 0; i < 10; i++) begin
        total++;
        if (stb_step[i] !== (i % 8)) $display("FAIL basic_step[%0d]: got %0d, required %0d", i, stb_step[i], i % 8);
        else passed++;
        total++;
        if (stb_gate[i] !== rows[i % 8]) $display("FAIL basic_gate[%0d]: got %h, required %h", i, stb_gate[i], rows[i % 8]);
        else passed++;
      end
      for (int i = 1; i < 10; i++) begin
        total++;
        if (stb_cyc[i] - stb_cyc[i-1] !== 12)
          $display("FAIL basic_period[%0d]: got %0d, required 12", i, stb_cyc[i] - stb_cyc[i-1]);
        else passed++;
        total++;
        if (gate_hist[i] !== 4) $display("FAIL basic_gate_len[%0d]: got %0d, required 4", i, gate_hist[i]);
        else passed++;
      end
    end
  endtask

  task automatic test_loop_len();
    int exp3 [15] = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 0, 1, 2, 3, 0, 1};
    pulse_stop();
    tempo_div = 28'd4;
    gate_len  = 28'd2;
    loop_len  = 3'd2;
    clear_log();
    pulse_play();
    wait_stb(5, 100);
    loop_len = 3'd5;   // during step 1 of the second pass
    wait_stb(13, 100);
    loop_len = 3'd1;   // during step 3: below the pointer, wraps at end of step
    wait_stb(15, 50);
    if (stb_step.size() >= 15) begin
      for (int i = 0; i < 15; i++) begin
        total++;
        if (stb_step[i] !== exp3[i]) $display("FAIL loop_step[%0d]: got %0d, required %0d", i, stb_step[i], exp3[i]);
        else passed++;
      end
    end
  endtask

  task automatic test_ack_holdoff();
    int req_bad = 0, addr_bad = 0, gate_bad = 0;
    pulse_stop();
    tempo_div = 28'd10;
    gate_len  = 28'd4;
    loop_len  = 3'd7;
    ack_block = 1'b1;
    clear_log();
    pulse_play();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (row_req !== 1'b1) req_bad++;
      if (row_addr !== 3'd0) addr_bad++;
      if (gate !== '0) gate_bad++;
    end
    total++; if (req_bad !== 0)  $display("FAIL hold_req: %0d cycles low, required 0", req_bad); else passed++;
    total++; if (addr_bad !== 0) $display("FAIL hold_addr: %0d cycles off, required 0", addr_bad); else passed++;
    total++; if (gate_bad !== 0) $display("FAIL hold_gate: %0d cycles high, required 0", gate_bad); else passed++;
    total++; if (stb_step.size() !== 0) $display("FAIL hold_stb: got %0d strobes, required 0", stb_step.size()); else passed++;
    ack_block = 1'b0;
    wait_stb(1, 10);
    if (stb_step.size() >= 1) begin
      total++;
      if (stb_step[0] !== 0 || stb_gate[0] !== rows[0])
        $display("FAIL hold_release: step=%0d gate=%h, required 0/%h", stb_step[0], stb_gate[0], rows[0]);
      else passed++;
    end
  endtask

  task automatic test_stop_in_wait();
    int spent = 0;
    // Still running from the previous scenario: play on to step 2, then stall the next fetch.
    wait_stb(3, 60);
    ack_block = 1'b1;
    while (!row_req && spent < 30) begin
      tick();
      spent++;
    end
    tick();
    total++; if (row_req !== 1'b1 || row_addr !== 3'd3)
      $display("FAIL wait_fetch: req=%b addr=%0d, required 1/3", row_req, row_addr); else passed++;
    clear_log();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    store_hold = 1'b1;
    row_ack  = 1'b1;
    row_data = 8'hFF;
    tick();
    row_ack = 1'b0;
    tick();
    tick();
    store_hold = 1'b0;
    total++; if (gate !== '0)      $display("FAIL late_ack_gate: got %h, required 00", gate); else passed++;
    total++; if (playing !== 1'b0) $display("FAIL late_ack_playing: got %b, required 0", playing); else passed++;
    total++; if (row_req !== 1'b0) $display("FAIL late_ack_req: got %b, required 0", row_req); else passed++;
    total++; if (stb_step.size() !== 0 || step !== '0)
      $display("FAIL late_ack_stb: strobes=%0d step=%0d, required 0/0", stb_step.size(), step); else passed++;
    ack_block = 1'b0;
    pulse_play();
    total++; if (row_req !== 1'b1 || row_addr !== 3'd0)
      $display("FAIL replay_addr: req=%b addr=%0d, required 1/0", row_req, row_addr); else passed++;
    wait_stb(1, 10);
    if (stb_step.size() >= 1) begin
      total++;
      if (stb_step[0] !== 0) $display("FAIL replay_step: got %0d, required 0", stb_step[0]); else passed++;
    end
  endtask

  task automatic test_clamps();
    pulse_stop();
    tempo_div = 28'd2;
    gate_len  = 28'd0;
    clear_log();
    play = 1'b1;
    stop = 1'b1;
    tick();
    play = 1'b0;
    stop = 1'b0;
    tick();
    total++; if (playing !== 1'b0 || row_req !== 1'b0)
      $display("FAIL play_stop: playing=%b req=%b, required 0/0", playing, row_req); else passed++;
    pulse_play();
    wait_stb(4, 60);
    if (stb_step.size() >= 4) begin
      for (int i = 1; i < 4; i++) begin
        total++;
        if (stb_cyc[i] - stb_cyc[i-1] !== 6)
          $display("FAIL min_tempo[%0d]: got %0d, required 6", i, stb_cyc[i] - stb_cyc[i-1]);
        else passed++;
      end
      total++;
      if (gate_hist[1] + gate_hist[2] + gate_hist[3] + gate_cnt !== 0)
        $display("FAIL zero_gate: got %0d high cycles, required 0", gate_hist[1] + gate_hist[2] + gate_hist[3] + gate_cnt);
      else passed++;
    end
    pulse_stop();
    tempo_div = 28'd6;
    gate_len  = 28'd20;
    clear_log();
    pulse_play();
    wait_stb(3, 60);
    if (stb_step.size() >= 3) begin
      for (int i = 1; i < 3; i++) begin
        total++;
        if (gate_hist[i] !== 5) $display("FAIL long_gate[%0d]: got %0d, required 5", i, gate_hist[i]);
        else passed++;
        total++;
        if (stb_cyc[i] - stb_cyc[i-1] !== 8)
          $display("FAIL long_period[%0d]: got %0d, required 8", i, stb_cyc[i] - stb_cyc[i-1]);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid_sound();
    pulse_stop();
    rows[0]   = 8'hFF;
    tempo_div = 28'd10;
    gate_len  = 28'd20;
    clear_log();
    pulse_play();
    wait_stb(1, 20);
    tick();
    total++; if (gate !== 8'hFF) $display("FAIL pre_reset_gate: got %h, required ff", gate); else passed++;
    #2 rst = 1'b0;
    #1;
    total++; if (gate !== '0)      $display("FAIL mid_reset_gate: got %h, required 00", gate); else passed++;
    total++; if (playing !== 1'b0) $display("FAIL mid_reset_playing: got %b, required 0", playing); else passed++;
    total++; if (row_req !== 1'b0) $display("FAIL mid_reset_req: got %b, required 0", row_req); else passed++;
    total++; if (step !== '0)      $display("FAIL mid_reset_step: got %0d, required 0", step); else passed++;
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    for (int n = 0; n < STEPS; n++) rows[n] = VOICES'(1) << n;
    test_reset();
    test_basic_loop();
    test_loop_len();
    test_ack_holdoff();
    test_stop_in_wait();
    test_clamps();
    test_reset_mid_sound();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
